// File: rtl/rca_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder that time-shares one 4-bit ripple-carry adder, LSB nibble first.
// Optional subtract mode (sub port, a - b) is built when RCA_SEQ_SUB_EN is defined.

module ripple_carry_adder (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] Sum,
   output logic       Cout
);
   logic [4:0] w_c;

   always_comb begin
      w_c    = '0;
      Sum    = '0;
      w_c[0] = Cin;
      for (int i = 0; i < 4; i++) begin
         Sum[i]     = A[i] ^ B[i] ^ w_c[i];
         w_c[i + 1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
      end
      Cout = w_c[4];
   end
endmodule

// state  | meaning
// IDLE   | waiting for a start handshake; start_ready high
// RUN    | one nibble per cycle through the shared adder; busy high
// DONE   | sum/cout valid and frozen until the result handshake
module rca_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
   input  logic             sub,
`endif
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             done_valid,
   input  logic             done_ready,
   output logic             busy
);
   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_sum;
   logic              r_cout;
   logic              r_carry;
   logic [IDXW-1:0]   r_idx;
   logic [3:0]        w_a_nib;
   logic [3:0]        w_b_nib;
   logic [3:0]        w_sum_nib;
   logic              w_cout_nib;
   logic              w_last;

   assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
   assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];
   assign w_last  = (r_idx == IDX_LAST);

   ripple_carry_adder u_rca (
      .A    (w_a_nib),
      .B    (w_b_nib),
      .Cin  (r_carry),
      .Sum  (w_sum_nib),
      .Cout (w_cout_nib)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start_valid)     w_state_nxt = S_RUN;
         S_RUN:   if (w_last)          w_state_nxt = S_DONE;
         S_DONE:  if (done_ready)      w_state_nxt = S_IDLE;
         default:                      w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_carry <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_valid) begin
                  r_a   <= a;
                  r_idx <= '0;
                  r_sum <= '0;
`ifdef RCA_SEQ_SUB_EN
                  // subtract as a + ~b + 1; cout then reads as "no borrow"
                  r_b     <= sub ? ~b : b;
                  r_carry <= sub ? 1'b1 : cin;
`else
                  r_b     <= b;
                  r_carry <= cin;
`endif
               end
            end
            S_RUN: begin
               r_sum[{r_idx, 2'b00} +: 4] <= w_sum_nib;
               r_carry                    <= w_cout_nib;
               r_idx                      <= r_idx + 1'b1;
               if (w_last) r_cout <= w_cout_nib;
            end
            default: ;
         endcase
      end
   end

   assign start_ready = (r_state == S_IDLE);
   assign busy        = (r_state == S_RUN);
   assign done_valid  = (r_state == S_DONE);
   assign sum         = r_sum;
   assign cout        = r_cout;
endmodule
